// File: rtl/exp_sum_acc.sv
// Accumulates VEC_LEN exp results into a sum and tracks the max element. oSumValid pulses one cycle after the last element.
// Optional EXP_SUM_ACC_SAT_EN makes the accumulator saturate and flag overflow; when undefined, it wraps.
module exp_sum_acc #(
  parameter int VEC_LEN = 16,
  parameter int ACC_W   = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [19:0]      iData,
  input  logic             iDataValid,
  input  logic             iClear,
  output logic [ACC_W-1:0] oSum,
  output logic [19:0]      oMax,
  output logic             oSumValid,
  output logic             oBusy,
  output logic             oOverflow
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CNT_W = $clog2(VEC_LEN);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [19:0]      maxVal;
  logic             ovf;

  logic [ACC_W-1:0] accNext;
  logic [19:0]      maxNext;
  logic             ovfNext;
  logic             lastElem;

`ifdef EXP_SUM_ACC_SAT_EN
  logic [ACC_W:0] sumExt;
  assign sumExt  = {1'b0, acc} + (ACC_W+1)'(iData);
  // Once clamped, the vector stays at all-ones even if later elements are zero.
  assign ovfNext = ovf | sumExt[ACC_W];
  assign accNext = ovfNext ? {ACC_W{1'b1}} : sumExt[ACC_W-1:0];
`else
  assign accNext = acc + ACC_W'(iData);
  assign ovfNext = 1'b0;
`endif

  assign maxNext  = (iData > maxVal) ? iData : maxVal;
  assign lastElem = (cnt == CNT_W'(VEC_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      maxVal <= '0;
      ovf    <= 1'b0;
      oSum   <= '0;
      oMax   <= '0;
    end else if (iClear) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (iDataValid) begin
            acc    <= ACC_W'(iData);
            maxVal <= iData;
            cnt    <= CNT_W'(1);
            ovf    <= 1'b0;
            state  <= ACC;
          end else begin
            state <= IDLE;
          end
        end
        ACC: begin
          if (iDataValid) begin
            acc    <= accNext;
            maxVal <= maxNext;
            ovf    <= ovfNext;
            if (lastElem) begin
              oSum  <= accNext;
              oMax  <= maxNext;
              cnt   <= '0;
              state <= DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign oSumValid = (state == DONE);
  assign oBusy     = (state == ACC);
  assign oOverflow = ovf;

endmodule

// File: tb/tb_exp_sum_acc.sv
// Randomized bench for exp_sum_acc: default build plus an ACC_W=22 instance, both checked against a vector-level model.
module tb_exp_sum_acc;
  localparam int VEC_LEN = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] iData = '0;
  logic        iDataValid = 1'b0;
  logic        iClear = 1'b0;

  logic [23:0] oSumA;
  logic [21:0] oSumB;
  logic [19:0] oMaxA, oMaxB;
  logic        oSumValidA, oSumValidB, oBusyA, oBusyB, oOverflowA, oOverflowB;

  exp_sum_acc #(.VEC_LEN(VEC_LEN), .ACC_W(24)) dutA (
    .clk(clk), .rst_n(rst_n), .iData(iData), .iDataValid(iDataValid), .iClear(iClear),
    .oSum(oSumA), .oMax(oMaxA), .oSumValid(oSumValidA), .oBusy(oBusyA), .oOverflow(oOverflowA)
  );

  exp_sum_acc #(.VEC_LEN(VEC_LEN), .ACC_W(22)) dutB (
    .clk(clk), .rst_n(rst_n), .iData(iData), .iDataValid(iDataValid), .iClear(iClear),
    .oSum(oSumB), .oMax(oMaxB), .oSumValid(oSumValidB), .oBusy(oBusyB), .oOverflow(oOverflowB)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  int unsigned elems[$];
  logic [31:0] expSum[2];
  logic [31:0] expMax;
  logic        expOvf[2];
  logic        expPulse;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int widthOf(input int k);
    return (k == 0) ? 24 : 22;
  endfunction

  task automatic checkOutputs();
    check("A.sumValid", 32'(oSumValidA), 32'(expPulse));
    check("B.sumValid", 32'(oSumValidB), 32'(expPulse));
    check("A.busy", 32'(oBusyA), 32'(elems.size() > 0));
    check("B.busy", 32'(oBusyB), 32'(elems.size() > 0));
    check("A.sum", 32'(oSumA), expSum[0]);
    check("B.sum", 32'(oSumB), expSum[1]);
    check("A.max", 32'(oMaxA), expMax);
    check("B.max", 32'(oMaxB), expMax);
    if (expPulse) begin
      check("A.overflow", 32'(oOverflowA), 32'(expOvf[0]));
      check("B.overflow", 32'(oOverflowB), 32'(expOvf[1]));
    end
  endtask

  // One clock: present inputs, let the edge happen, advance the model, compare.
  task automatic cycle(input logic v, input logic [19:0] d, input logic c);
    longint unsigned total;
    longint unsigned lim;
    int unsigned mx;
    iDataValid = v;
    iData      = d;
    iClear     = c;
    @(posedge clk);
    #1;
    expPulse = 1'b0;
    if (c) begin
      elems.delete();
    end else if (v) begin
      elems.push_back(32'(d));
      if (elems.size() == VEC_LEN) begin
        total = 0;
        mx = 0;
        foreach (elems[i]) begin
          total += elems[i];
          if (elems[i] > mx) mx = elems[i];
        end
        for (int k = 0; k < 2; k++) begin
          lim = 64'd1 << widthOf(k);
`ifdef EXP_SUM_ACC_SAT_EN
          expOvf[k] = (total >= lim);
          expSum[k] = expOvf[k] ? 32'(lim - 1) : 32'(total);
`else
          expOvf[k] = 1'b0;
          expSum[k] = 32'(total % lim);
`endif
        end
        expMax   = mx;
        expPulse = 1'b1;
        elems.delete();
      end
    end
    checkOutputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 20'h0, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, ".A.sum"}, 32'(oSumA), 32'h0);
    check({tag, ".B.sum"}, 32'(oSumB), 32'h0);
    check({tag, ".A.max"}, 32'(oMaxA), 32'h0);
    check({tag, ".A.sumValid"}, 32'(oSumValidA), 32'h0);
    check({tag, ".A.busy"}, 32'(oBusyA), 32'h0);
    check({tag, ".B.busy"}, 32'(oBusyB), 32'h0);
    check({tag, ".A.overflow"}, 32'(oOverflowA), 32'h0);
    check({tag, ".B.overflow"}, 32'(oOverflowB), 32'h0);
  endtask

  // Reset asserted away from the clock edge, held across one rising edge.
  task automatic pulseReset();
    iDataValid = 1'b0;
    iClear     = 1'b0;
    rst_n      = 1'b0;
    #2;
    elems.delete();
    expSum[0] = '0;
    expSum[1] = '0;
    expMax    = '0;
    expPulse  = 1'b0;
    checkAllZero("asyncReset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [19:0] d;

  initial begin
    expSum[0] = '0;
    expSum[1] = '0;
    expMax    = '0;
    expOvf[0] = 1'b0;
    expOvf[1] = 1'b0;
    expPulse  = 1'b0;

    @(posedge clk);
    @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < VEC_LEN; i++) cycle(1'b1, 20'h00010, 1'b0);
    idle(3);

    for (int i = 1; i <= VEC_LEN; i++) begin
      cycle(1'b1, 20'(i << 4), 1'b0);
      idle($urandom_range(0, 3));
    end
    idle(2);

    for (int i = 0; i < 2 * VEC_LEN; i++) cycle(1'b1, 20'($urandom), 1'b0);
    idle(2);

    for (int i = 0; i < VEC_LEN; i++) cycle(1'b1, 20'hFFFFF, 1'b0);
    idle(3);

    for (int i = 0; i < 9; i++) cycle(1'b1, 20'($urandom), 1'b0);
    cycle(1'b1, 20'($urandom), 1'b1);
    for (int i = 0; i < VEC_LEN; i++) cycle(1'b1, 20'h00010, 1'b0);
    idle(2);

    for (int i = 0; i < 7; i++) cycle(1'b1, 20'($urandom), 1'b0);
    pulseReset();
    for (int i = 0; i < VEC_LEN; i++) cycle(1'b1, 20'($urandom), 1'b0);
    idle(2);

    for (int i = 0; i < 600; i++) begin
      d = ($urandom_range(0, 2) == 0) ? 20'(20'hFFFFF - $urandom_range(0, 255)) : 20'($urandom);
      cycle($urandom_range(0, 9) < 7, d, $urandom_range(0, 49) == 0);
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
